// File: rtl/bp_be_stream_prefetch_engine_pkg.sv
// Shared types for the multi-stream BE prefetch engine: stream entry layout, per-entry state, stride helper.
// Pure declarations; no timing or flow control of its own.
package bp_be_stream_prefetch_engine_pkg;

  localparam int vaddr_width_p  = 39;
  localparam int stride_width_p = 8;
  localparam int count_width_p  = 8;
  localparam int credit_width_lp = 4;

  typedef enum logic {e_pf_idle, e_pf_run} bp_be_pf_state_e;

  typedef struct packed {
    logic                       v;
    logic [vaddr_width_p-1:0]   pc;
    logic [vaddr_width_p-1:0]   next_addr;
    logic [stride_width_p-1:0]  stride;
    logic [count_width_p-1:0]   remaining;
    logic [credit_width_lp-1:0] credit;
  } bp_be_pf_stream_s;

  function automatic logic [vaddr_width_p-1:0] pf_sext_stride(input logic [stride_width_p-1:0] s);
    return {{(vaddr_width_p-stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

endpackage

// File: rtl/bp_be_stream_prefetch_engine_if.sv
// Alloc/demand/prefetch handshake bundle between the scheduler side and the prefetch engine.
// Wires only; pref_* follows valid/yumi, everything else is single-cycle strobes.
interface bp_be_stream_prefetch_engine_if
  import bp_be_stream_prefetch_engine_pkg::*;
  #(parameter int streams_p = 4);

  localparam int idx_width_lp = $clog2(streams_p);

  logic                      flush_i;
  logic                      alloc_v_i;
  logic [vaddr_width_p-1:0]  alloc_pc_i;
  logic [vaddr_width_p-1:0]  alloc_addr_i;
  logic [stride_width_p-1:0] alloc_stride_i;
  logic [count_width_p-1:0]  alloc_count_i;
  logic                      demand_v_i;
  logic [vaddr_width_p-1:0]  demand_pc_i;
  logic                      pref_v_o;
  logic [vaddr_width_p-1:0]  pref_vaddr_o;
  logic [idx_width_lp-1:0]   pref_stream_o;
  logic                      pref_yumi_i;
  logic                      busy_o;

  modport master (
    output flush_i, alloc_v_i, alloc_pc_i, alloc_addr_i, alloc_stride_i, alloc_count_i,
    output demand_v_i, demand_pc_i, pref_yumi_i,
    input  pref_v_o, pref_vaddr_o, pref_stream_o, busy_o
  );

  modport slave (
    input  flush_i, alloc_v_i, alloc_pc_i, alloc_addr_i, alloc_stride_i, alloc_count_i,
    input  demand_v_i, demand_pc_i, pref_yumi_i,
    output pref_v_o, pref_vaddr_o, pref_stream_o, busy_o
  );

endinterface

// File: rtl/bp_be_stream_prefetch_engine_arb.sv
// Round-robin grant over the eligible-stream vector; pointer moves to winner+1 when the grant is taken.
// Combinational grant, registered pointer; an untaken grant leaves the pointer in place.
module bp_be_stream_prefetch_engine_arb #(
  parameter int width_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [width_p-1:0]         reqs_i,
  input  logic                       yumi_i,
  output logic                       grant_v_o,
  output logic [$clog2(width_p)-1:0] grant_idx_o
);

  localparam int idx_width_lp = $clog2(width_p);

  logic [idx_width_lp-1:0] ptr_r;
  int                      j;

  always_comb begin
    grant_v_o   = 1'b0;
    grant_idx_o = '0;
    j           = 0;
    for (int k = 0; k < width_p; k++) begin
      j = (int'(ptr_r) + k) % width_p;
      if (!grant_v_o && reqs_i[j]) begin
        grant_v_o   = 1'b1;
        grant_idx_o = idx_width_lp'(j);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r <= '0;
    end else if (yumi_i) begin
      ptr_r <= (grant_idx_o == idx_width_lp'(width_p-1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/bp_be_stream_prefetch_engine.sv
// Tracks up to streams_p strided load streams and issues one prefetch vaddr at a time, credit-limited per stream.
// Alloc at edge N gives pref_v_o after edge N+1; request holds until yumi, back-to-back yumi sustains 1 req/cycle.
module bp_be_stream_prefetch_engine
  import bp_be_stream_prefetch_engine_pkg::*;
  #(parameter int streams_p = 4,
    parameter int degree_p  = 2)
  (
    input logic clk_i,
    input logic reset_n_i,
    bp_be_stream_prefetch_engine_if.slave io
  );

  localparam int idx_width_lp = $clog2(streams_p);
  localparam logic [credit_width_lp-1:0] degree_lp = credit_width_lp'(degree_p);

  bp_be_pf_stream_s        stream_r [streams_p];
  bp_be_pf_stream_s        stream_n [streams_p];
  bp_be_pf_state_e         state    [streams_p];
  logic [streams_p-1:0]    eligible, v_vec, alloc_hit, demand_hit;
  logic [idx_width_lp-1:0] victim_r, victim_n, alloc_idx, grant_idx, pref_stream_r;
  logic [vaddr_width_p-1:0] pref_vaddr_r;
  logic                    pref_v_r, grant_v, load_en, grant_take, alloc_take, use_victim;

  assign load_en    = ~pref_v_r | io.pref_yumi_i;
  assign grant_take = load_en & grant_v & ~io.flush_i;
  assign alloc_take = io.alloc_v_i & (io.alloc_count_i != '0) & ~io.flush_i;

  bp_be_stream_prefetch_engine_arb #(.width_p(streams_p)) arb (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .reqs_i      (eligible),
    .yumi_i      (grant_take),
    .grant_v_o   (grant_v),
    .grant_idx_o (grant_idx)
  );

  // CAM lookup: a pc hit refreshes in place, otherwise lowest idle entry, otherwise the victim.
  always_comb begin
    alloc_hit  = '0;
    demand_hit = '0;
    alloc_idx  = victim_r;
    use_victim = 1'b1;
    for (int i = 0; i < streams_p; i++) begin
      state[i]      = stream_r[i].v ? e_pf_run : e_pf_idle;
      alloc_hit[i]  = stream_r[i].v & (stream_r[i].pc == io.alloc_pc_i);
      demand_hit[i] = io.demand_v_i & stream_r[i].v & (stream_r[i].pc == io.demand_pc_i);
    end
    for (int i = streams_p-1; i >= 0; i--) begin
      if (!stream_r[i].v) begin
        alloc_idx  = idx_width_lp'(i);
        use_victim = 1'b0;
      end
    end
    for (int i = streams_p-1; i >= 0; i--) begin
      if (alloc_hit[i]) begin
        alloc_idx  = idx_width_lp'(i);
        use_victim = 1'b0;
      end
    end
  end

  always_comb begin
    victim_n = victim_r;
    for (int i = 0; i < streams_p; i++) begin
      stream_n[i] = stream_r[i];
      case (state[i])
        e_pf_run: begin
          if (grant_take && grant_idx == idx_width_lp'(i)) begin
            stream_n[i].next_addr = stream_r[i].next_addr + pf_sext_stride(stream_r[i].stride);
            stream_n[i].remaining = stream_r[i].remaining - 1'b1;
            if (!demand_hit[i])
              stream_n[i].credit = stream_r[i].credit - 1'b1;
            if (stream_r[i].remaining == count_width_p'(1))
              stream_n[i].v = 1'b0;
          end else if (demand_hit[i] && stream_r[i].credit != degree_lp) begin
            stream_n[i].credit = stream_r[i].credit + 1'b1;
          end
        end
        default: ;
      endcase
      // Alloc overrides the grant update; the output register still takes the old next_addr.
      if (alloc_take && alloc_idx == idx_width_lp'(i)) begin
        stream_n[i].v         = 1'b1;
        stream_n[i].pc        = io.alloc_pc_i;
        stream_n[i].next_addr = io.alloc_addr_i;
        stream_n[i].stride    = io.alloc_stride_i;
        stream_n[i].remaining = io.alloc_count_i;
        stream_n[i].credit    = degree_lp;
      end
      if (io.flush_i)
        stream_n[i].v = 1'b0;
    end
    if (alloc_take && use_victim)
      victim_n = (victim_r == idx_width_lp'(streams_p-1)) ? '0 : victim_r + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < streams_p; i++) begin
      v_vec[i]    = stream_r[i].v;
      eligible[i] = stream_r[i].v & (stream_r[i].credit != '0) & (stream_r[i].remaining != '0);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < streams_p; i++)
        stream_r[i] <= '0;
      victim_r      <= '0;
      pref_v_r      <= 1'b0;
      pref_vaddr_r  <= '0;
      pref_stream_r <= '0;
    end else begin
      stream_r <= stream_n;
      victim_r <= victim_n;
      if (io.flush_i) begin
        pref_v_r <= 1'b0;
      end else if (load_en) begin
        pref_v_r <= grant_v;
        if (grant_v) begin
          pref_vaddr_r  <= stream_r[grant_idx].next_addr;
          pref_stream_r <= grant_idx;
        end
      end
    end
  end

  assign io.pref_v_o      = pref_v_r;
  assign io.pref_vaddr_o  = pref_vaddr_r;
  assign io.pref_stream_o = pref_stream_r;
  assign io.busy_o        = |v_vec;

endmodule

// File: tb/tb_bp_be_stream_prefetch_engine.sv
// Directed bench for the stream prefetch engine: expected requests queued at stimulus time,
// a negedge monitor pops and compares each accepted request.
module tb_bp_be_stream_prefetch_engine;
  import bp_be_stream_prefetch_engine_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_be_stream_prefetch_engine_if #(.streams_p(4)) pf_if ();

  bp_be_stream_prefetch_engine #(.streams_p(4), .degree_p(2)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .io        (pf_if)
  );

  typedef struct packed {
    logic [1:0]  stream;
    logic [38:0] vaddr;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [1:0] s, input logic [38:0] a);
    req_t r;
    r.stream = s;
    r.vaddr  = a;
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    req_t e;
    if (reset_n && pf_if.pref_v_o && pf_if.pref_yumi_i && !pf_if.flush_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_req: got stream %0d vaddr 0x%0h, expected no request",
                 pf_if.pref_stream_o, pf_if.pref_vaddr_o);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (pf_if.pref_stream_o === e.stream && pf_if.pref_vaddr_o === e.vaddr) passes++;
        else $display("FAIL req: got stream %0d vaddr 0x%0h, expected stream %0d vaddr 0x%0h",
                      pf_if.pref_stream_o, pf_if.pref_vaddr_o, e.stream, e.vaddr);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_alloc(input logic [38:0] pc, input logic [38:0] addr,
                          input logic [7:0] stride, input logic [7:0] count);
    pf_if.alloc_v_i      = 1'b1;
    pf_if.alloc_pc_i     = pc;
    pf_if.alloc_addr_i   = addr;
    pf_if.alloc_stride_i = stride;
    pf_if.alloc_count_i  = count;
    step();
    pf_if.alloc_v_i      = 1'b0;
  endtask

  task automatic do_demand(input logic [38:0] pc);
    pf_if.demand_v_i  = 1'b1;
    pf_if.demand_pc_i = pc;
    step();
    pf_if.demand_v_i  = 1'b0;
  endtask

  task automatic do_flush();
    pf_if.flush_i = 1'b1;
    step();
    pf_if.flush_i = 1'b0;
  endtask

  task automatic drain(input string name);
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    pf_if.flush_i = 0; pf_if.alloc_v_i = 0; pf_if.alloc_pc_i = 0; pf_if.alloc_addr_i = 0;
    pf_if.alloc_stride_i = 0; pf_if.alloc_count_i = 0; pf_if.demand_v_i = 0;
    pf_if.demand_pc_i = 0; pf_if.pref_yumi_i = 0;

    // Reset state
    #12;
    check("rst_pref_v", pf_if.pref_v_o, 0);
    check("rst_vaddr", pf_if.pref_vaddr_o, 0);
    check("rst_stream", pf_if.pref_stream_o, 0);
    check("rst_busy", pf_if.busy_o, 0);
    #10 reset_n = 1'b1;
    step();

    // 1: single stream, yumi tied high, demand every cycle
    pf_if.pref_yumi_i = 1'b1;
    pf_if.demand_v_i  = 1'b1;
    pf_if.demand_pc_i = 39'h80000200;
    push(0, 39'h1000); push(0, 39'h1008); push(0, 39'h1010);
    do_alloc(39'h80000200, 39'h1000, 8'd8, 8'd3);
    check("t1_lat_edge_n", pf_if.pref_v_o, 0);
    check("t1_busy_on", pf_if.busy_o, 1);
    step();
    check("t1_lat_edge_n1", pf_if.pref_v_o, 1);
    check("t1_first_vaddr", pf_if.pref_vaddr_o, 39'h1000);
    step(5);
    pf_if.demand_v_i = 1'b0;
    check("t1_done_v", pf_if.pref_v_o, 0);
    check("t1_done_busy", pf_if.busy_o, 0);
    drain("t1_drain");

    // 2: credit throttle without demand, then one demand releases one more
    push(0, 39'h2000); push(0, 39'h2010);
    do_alloc(39'h80000300, 39'h2000, 8'd16, 8'd10);
    step(8);
    check("t2_stall_v", pf_if.pref_v_o, 0);
    check("t2_stall_busy", pf_if.busy_o, 1);
    drain("t2_drain_a");
    push(0, 39'h2020);
    do_demand(39'h80000300);
    step(6);
    check("t2_after_demand_v", pf_if.pref_v_o, 0);
    drain("t2_drain_b");
    do_flush();

    // 3: negative stride wraps below zero
    push(0, 39'h4); push(0, 39'h7F_FFFF_FFFC);
    do_alloc(39'h80000400, 39'h4, 8'hF8, 8'd2);
    step(5);
    check("t3_busy", pf_if.busy_o, 0);
    drain("t3_drain");

    // 4: four streams round-robin, then victim replacement when full
    pf_if.pref_yumi_i = 1'b0;
    push(0, 39'h10000); push(1, 39'h20000); push(2, 39'h30000); push(3, 39'h40000);
    push(0, 39'h10004); push(1, 39'h20004); push(2, 39'h30004); push(3, 39'h40004);
    for (int i = 0; i < 4; i++)
      do_alloc(39'h80001000 + 39'(i * 'h100), 39'(('h10000) * (i + 1)), 8'd4, 8'd10);
    check("t4_held_v", pf_if.pref_v_o, 1);
    check("t4_held_stream", pf_if.pref_stream_o, 0);
    pf_if.pref_yumi_i = 1'b1;
    step(12);
    check("t4_stall_v", pf_if.pref_v_o, 0);
    drain("t4_drain_rr");
    push(0, 39'h50000); push(1, 39'h60000);
    do_alloc(39'h80002000, 39'h50000, 8'd4, 8'd1);
    do_alloc(39'h80003000, 39'h60000, 8'd4, 8'd1);
    step(4);
    check("t4_busy", pf_if.busy_o, 1);
    drain("t4_drain_victim");
    do_flush();

    // 5: backpressure holds the request; same-pc refresh does not disturb it
    pf_if.pref_yumi_i = 1'b0;
    do_alloc(39'h80004000, 39'h7000, 8'd8, 8'd5);
    step();
    check("t5_v", pf_if.pref_v_o, 1);
    for (int c = 0; c < 5; c++) begin
      check("t5_hold_vaddr", pf_if.pref_vaddr_o, 39'h7000);
      check("t5_hold_stream", pf_if.pref_stream_o, 0);
      if (c == 1) do_alloc(39'h80004000, 39'h9000, 8'd8, 8'd5);
      else step();
    end
    push(0, 39'h7000); push(0, 39'h9000); push(0, 39'h9008);
    pf_if.pref_yumi_i = 1'b1;
    step(6);
    check("t5_stall_v", pf_if.pref_v_o, 0);
    drain("t5_drain");

    // 6: flush with yumi and alloc in the same cycle, then async reset mid-stream
    pf_if.pref_yumi_i = 1'b0;
    do_demand(39'h80004000);
    step();
    check("t6_pre_v", pf_if.pref_v_o, 1);
    pf_if.flush_i = 1'b1; pf_if.pref_yumi_i = 1'b1;
    pf_if.alloc_v_i = 1'b1; pf_if.alloc_pc_i = 39'h80005000; pf_if.alloc_addr_i = 39'hB000;
    pf_if.alloc_stride_i = 8'd8; pf_if.alloc_count_i = 8'd4;
    step();
    pf_if.flush_i = 1'b0; pf_if.alloc_v_i = 1'b0;
    check("t6_flush_v", pf_if.pref_v_o, 0);
    check("t6_flush_busy", pf_if.busy_o, 0);
    step(3);
    check("t6_no_stream_v", pf_if.pref_v_o, 0);
    check("t6_no_stream_busy", pf_if.busy_o, 0);
    pf_if.pref_yumi_i = 1'b0;
    do_alloc(39'h80006000, 39'hA000, 8'd8, 8'd5);
    step();
    check("t6_pre_rst_v", pf_if.pref_v_o, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_v", pf_if.pref_v_o, 0);
    check("t6_rst_vaddr", pf_if.pref_vaddr_o, 0);
    check("t6_rst_stream", pf_if.pref_stream_o, 0);
    check("t6_rst_busy", pf_if.busy_o, 0);
    #3 reset_n = 1'b1;
    step(2);
    check("t6_post_rst_v", pf_if.pref_v_o, 0);
    drain("final_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
